// File: rtl/inst_display_scan.sv
// ---------------------------------------------------------------------------
// inst_display_scan
//
// Shows the 8-character packed instruction bus on an 8-digit common-anode
// 7-segment display. The bus comes from the slow sec_clock domain. It is
// synchronised into clk and captured into a display snapshot once per scan
// frame. A capture only happens when the bus has been steady, so a frame
// never shows a torn mix of old and new characters.
//
// Parameters:
//   REFRESH_DIV : clk cycles each digit stays lit (legal >= 2)
//   NUM_DIGITS  : digit count (fixed at 8; instruction is 5*NUM_DIGITS bits)
//
// Ports:
//   clk         : fast system clock
//   rst         : asynchronous reset, active-low
//   instruction : packed 5-bit codes, [39:35] leftmost .. [4:0] rightmost;
//                 asynchronous to clk and quasi-static
//   enable      : 1 = display on, 0 = blanked (scan keeps running)
//   an          : digit anodes, active-low, an[7] leftmost
//   seg         : segments {g,f,e,d,c,b,a}, active-low
//   dp          : decimal point, active-low, held off
//   frame_done  : one-cycle pulse at each frame boundary
// ---------------------------------------------------------------------------
module inst_display_scan #(
    parameter int REFRESH_DIV = 100000,
    parameter int NUM_DIGITS  = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [5*NUM_DIGITS-1:0]   instruction,
    input  logic                      enable,
    output logic [NUM_DIGITS-1:0]     an,
    output logic [6:0]                seg,
    output logic                      dp,
    output logic                      frame_done
);

    localparam int TICK_W = $clog2(REFRESH_DIV);
    localparam int IDX_W  = $clog2(NUM_DIGITS);
    localparam int BUS_W  = 5 * NUM_DIGITS;

    // Active-high glyph for a 5-bit letter code: 0 = blank, 1..26 = A..Z,
    // 27..31 = dash.
    function automatic logic [6:0] glyph_of(input logic [4:0] code);
        logic [6:0] g;
        case (code)
            5'd0:    g = 7'h00;
            5'd1:    g = 7'h77;   // A
            5'd2:    g = 7'h7C;   // B
            5'd3:    g = 7'h39;   // C
            5'd4:    g = 7'h5E;   // D
            5'd5:    g = 7'h79;   // E
            5'd6:    g = 7'h71;   // F
            5'd7:    g = 7'h3D;   // G
            5'd8:    g = 7'h76;   // H
            5'd9:    g = 7'h30;   // I
            5'd10:   g = 7'h1E;   // J
            5'd11:   g = 7'h75;   // K
            5'd12:   g = 7'h38;   // L
            5'd13:   g = 7'h37;   // M
            5'd14:   g = 7'h54;   // N
            5'd15:   g = 7'h3F;   // O
            5'd16:   g = 7'h73;   // P
            5'd17:   g = 7'h67;   // Q
            5'd18:   g = 7'h50;   // R
            5'd19:   g = 7'h6D;   // S
            5'd20:   g = 7'h78;   // T
            5'd21:   g = 7'h3E;   // U
            5'd22:   g = 7'h1C;   // V
            5'd23:   g = 7'h2A;   // W
            5'd24:   g = 7'h49;   // X
            5'd25:   g = 7'h6E;   // Y
            5'd26:   g = 7'h5B;   // Z
            default: g = 7'h40;   // dash
        endcase
        return g;
    endfunction

    // State
    logic [TICK_W-1:0]     tick_reg,      tick_next;
    logic [IDX_W-1:0]      digit_idx_reg, digit_idx_next;
    logic [BUS_W-1:0]      s1_reg, s2_reg, s3_reg;
    logic [BUS_W-1:0]      disp_reg,      disp_next;
    logic [NUM_DIGITS-1:0] an_reg,        an_next;
    logic [6:0]            seg_reg,       seg_next;
    logic                  frame_done_reg;

    logic                  tick_wrap;
    logic                  last_digit;
    logic                  frame_boundary;
    logic                  stable;
    logic [4:0]            codes [NUM_DIGITS];

    // s1 may go metastable; s2 is the first trustworthy copy. Comparing s2
    // with s3 tells us the bus held the same value over two clk cycles, which
    // is the condition for taking a snapshot.
    assign stable = (s2_reg == s3_reg);

    // Per-digit code slices and one-hot active-low anode select.
    generate
        for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
            assign codes[gi]   = disp_reg[5*gi +: 5];
            assign an_next[gi] = !(enable && (digit_idx_reg == IDX_W'(gi)));
        end
    endgenerate

    always_comb begin
        tick_wrap      = (tick_reg == TICK_W'(REFRESH_DIV - 1));
        last_digit     = (digit_idx_reg == IDX_W'(NUM_DIGITS - 1));
        frame_boundary = tick_wrap && last_digit;

        tick_next      = tick_wrap ? '0 : tick_reg + TICK_W'(1);

        digit_idx_next = digit_idx_reg;
        if (tick_wrap) begin
            digit_idx_next = last_digit ? '0 : digit_idx_reg + IDX_W'(1);
        end

        // The snapshot only moves at a frame boundary, so a frame is always
        // drawn from a single bus value.
        disp_next = disp_reg;
        if (frame_boundary && stable) begin
            disp_next = s2_reg;
        end

        seg_next = enable ? ~glyph_of(codes[digit_idx_reg]) : 7'h7F;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_reg       <= '0;
            digit_idx_reg  <= '0;
            s1_reg         <= '0;
            s2_reg         <= '0;
            s3_reg         <= '0;
            disp_reg       <= '0;
            an_reg         <= '1;
            seg_reg        <= 7'h7F;
            frame_done_reg <= 1'b0;
        end else begin
            tick_reg       <= tick_next;
            digit_idx_reg  <= digit_idx_next;
            s1_reg         <= instruction;
            s2_reg         <= s1_reg;
            s3_reg         <= s2_reg;
            disp_reg       <= disp_next;
            an_reg         <= an_next;
            seg_reg        <= seg_next;
            frame_done_reg <= frame_boundary;
        end
    end

    assign an         = an_reg;
    assign seg        = seg_reg;
    assign dp         = 1'b1;
    assign frame_done = frame_done_reg;

endmodule

// File: doc/inst_display_scan.md
Name: inst_display_scan

Overview:
- Downstream consumer of the 40-bit packed instruction bus produced by the instruction shifter (8 characters × 5-bit letter code, slow `sec_clock` domain).
- Synchronises the bus into the fast board clock domain and latches a tear-free snapshot once per scan frame.
- Decodes each 5-bit code to a 7-segment glyph and time-multiplexes the 8 common-anode digits.

Parameters:
- REFRESH_DIV, 100000, clk cycles each digit stays lit (1 kHz per digit at 100 MHz); legal ≥ 2.
- NUM_DIGITS, 8, digit count; fixed, instruction width = 5*NUM_DIGITS.

Ports:
- clk  in  1  fast system clock.
- rst  in  1  asynchronous reset, active-low (asserted when 0).
- instruction  in  40  packed codes; [39:35] leftmost char, [4:0] rightmost; asynchronous to clk, quasi-static.
- enable  in  1  1 = display on, 0 = blanked.
- an  out  8  digit anodes, active-low; an[7] leftmost.
- seg  out  7  segments {g,f,e,d,c,b,a}, active-low.
- dp  out  1  decimal point, active-low; always 1.
- frame_done  out  1  one-cycle pulse at each frame boundary.

Behaviour:
- Reset (rst=0, async): tick=0, digit_idx=0, sync stages=0, disp_reg=0, an=8'hFF, seg=7'h7F, dp=1, frame_done=0.
- Synchroniser:
  - s1 <= instruction; s2 <= s1; s3 <= s2 (all 40-bit).
  - stable = (s2 == s3).
- Tick counter:
  - Counts 0..REFRESH_DIV-1, then wraps to 0.
  - On wrap, digit_idx increments 0→1→…→7→0.
- Frame boundary = tick wrap while digit_idx==7. On that same clk edge:
  - digit_idx becomes 0.
  - frame_done=1 for exactly one cycle.
  - If stable, disp_reg <= s2; otherwise disp_reg is unchanged.
- Snapshot rules:
  - disp_reg changes at no other time; changes to instruction mid-frame never appear mid-frame.
  - Worst-case display latency for a stable new value: 3 clk + 1 frame.
- Decode: code = disp_reg[5*digit_idx+4 -: 5]. Active-high glyph hex (seg = ~glyph):
  - 0=blank 00
  - A 77, B 7C, C 39, D 5E, E 79, F 71, G 3D, H 76, I 30, J 1E, K 75, L 38, M 37
  - N 54, O 3F, P 73, Q 67, R 50, S 6D, T 78, U 3E, V 1C, W 2A, X 49, Y 6E, Z 5B
  - codes 27–31 = dash 40.
- Outputs registered, updated every clk from the current digit_idx and disp_reg (one cycle behind digit_idx):
  - an <= enable ? ~(8'b1 << digit_idx) : 8'hFF.
  - seg <= enable ? ~glyph : 7'h7F.
- Exactly one an bit is low whenever enable=1 (never two simultaneously).
- enable=0 blanks outputs only; tick, digit_idx, sync and snapshot keep running.
- Reset mid-scan: all state returns to reset values immediately; the scan restarts at digit 0 after release, with a blank display until the first stable snapshot.

Test Plan:
- Reset: hold rst=0 with arbitrary inputs → an=FF, seg=7F, dp=1, frame_done=0. Release with enable=1 and REFRESH_DIV=4 → one clk later an=FE, seg=7F (disp_reg still 0).
- "TRANSFER": drive instruction=40'hA482E998B2 stable, REFRESH_DIV=4, enable=1. After the second frame_done, the scan shows:
  - an=7F seg=07 (T); BF 2F (R); DF 08 (A); EF 2B (N).
  - F7 12 (S); FB 0E (F); FD 06 (E); FE 2F (R).
  - frame_done pulses every 32 clk.
- Mid-frame change: switch instruction from 0 to 40'hA482E998B2 while digit_idx=3 → digits 3..7 of the current frame stay blank; new glyphs appear only from the frame after the next frame_done.
- Unstable bus: toggle instruction between two values every clk across a frame boundary → disp_reg and seg pattern are unchanged through that boundary.
- enable: deassert mid-frame → next clk an=FF, seg=7F. Reassert → the scan resumes at the current digit_idx, with no restart of frame_done timing.
- Async reset mid-scan at digit_idx=5 → an=FF, seg=7F immediately, without waiting for clk. After release the scan restarts at digit 0 and the display stays blank until the first stable frame-boundary snapshot.
